byte_unstriping_rx: RTL and testbench
=====================================

// Module: byte_unstriping_rx
// PURPOSE
//  Receive-side counterpart of the TX byte striper. Takes the four 8-bit lane streams, absorbs
//  inter-lane skew in per-lane FIFOs and rebuilds the original serial byte stream.
//  Byte order out is lane0, lane1, lane2, lane3, repeating.
//  Sits between the lane receivers (or the striper directly, in loopback benches) and the
//  byte-wide consumer.
// PARAMETERS
//  DEPTH     4  entries per lane FIFO, power of two, >=2; bounds the skew that can be absorbed
//  SKEW_MAX  8  max cycles spent in ALIGN before declaring a skew error
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  valid_in0-3  in   1  lane N byte valid, one bit per lane
//  data_in0-3   in   8  lane N byte, sampled when valid_inN=1
//  data_out     out  8  reassembled byte, registered
//  valid_out    out  1  data_out holds a new byte this cycle
//  aligned      out  1  high while in RUN
//  overflow_err out  1  sticky: a lane FIFO was written while full
//  skew_err     out  1  sticky: ALIGN timed out
// BEHAVIOUR
//  Reset (async, any time, incl. mid-packet):
//   - Outputs clear immediately: data_out=8'h00; valid_out, aligned, overflow_err, skew_err = 0.
//   - FIFOs empty, lane_ptr=0, skew counter=0, state=IDLE.
//  Lane FIFOs:
//   - valid_inN=1 pushes data_inN at the edge; the byte is visible (count>0) the next cycle.
//   - Push and pop on the same lane in the same cycle are legal; the count is unchanged.
//   - Push to a full FIFO with no pop that cycle: the byte is dropped, overflow_err<=1, and the
//     state goes to ERROR.
//   - Push to a full FIFO together with a pop is NOT an overflow.
//  FSM (states IDLE, ALIGN, RUN, ERROR):
//   - IDLE:  all four FIFOs non-empty -> RUN.
//            Else any FIFO non-empty -> ALIGN, skew counter cleared.
//   - ALIGN: all four non-empty -> RUN, lane_ptr=0.
//            Else counter increments; when it reaches SKEW_MAX -> ERROR, skew_err<=1.
//   - RUN:   each cycle, if FIFO[lane_ptr] is non-empty:
//              pop it; data_out<=head; valid_out<=1; lane_ptr<=lane_ptr+1 (2-bit wrap 3->0).
//            Otherwise valid_out<=0 and lane_ptr holds (stall; order is never broken).
//            If lane_ptr==0 and all FIFOs are empty -> IDLE (word boundary, realign on next data).
//   - ERROR: valid_out=0; writes ignored; FIFOs flushed; exit only via reset.
//  Outputs and latency:
//   - aligned=1 exactly while state==RUN.
//   - data_out holds its last value when valid_out=0.
//   - Four lanes written on edge E0: FSM enters RUN at E1.
//     lane0 byte on data_out after E2; lane1/2/3 after E3/E4/E5.
//   - Steady state with no lane gaps: one byte per clock.
//   - Input word rate is at most 1 per 4 clocks in steady state; faster input overflows the FIFOs.
// TESTING
//  1 Aligned word:
//    valid_in0-3=1, data 11/22/33/44 on one edge
//    -> data_out 11,22,33,44 on 4 consecutive cycles starting 2 clocks later; aligned=1.
//  2 Skew:
//    lane2 valid 3 cycles after lanes 0/1/3, same data as test 1
//    -> FSM waits in ALIGN; output 11,22,33,44 in order; skew_err=0.
//  3 Skew timeout:
//    lanes 0-2 valid, lane3 never
//    -> after SKEW_MAX=8 ALIGN cycles skew_err=1, valid_out stays 0 until reset.
//  4 Overflow:
//    DEPTH+1 writes to lane0 only, back-to-back
//    -> overflow_err=1 on the 5th write edge; state ERROR; no bytes emitted.
//  5 Loopback:
//    TX striper drives 0x00..0x0F into this block
//    -> data_out reproduces 0x00..0x0F in order; no errors.
//  6 Reset mid-RUN:
//    assert reset between TX edges after the 2nd byte
//    -> all outputs clear immediately; the next aligned word 55/66/77/88 reassembles correctly.

Source files
------------

// File: rtl/byte_unstriping_rx.sv
// Rebuilds a serial byte stream from four byte lanes, absorbing inter-lane skew
// in small per-lane FIFOs. Output order is lane0, lane1, lane2, lane3, repeating.
module byte_unstriping_rx #(
    parameter int DEPTH    = 4,
    parameter int SKEW_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       aligned,
    output logic       overflow_err,
    output logic       skew_err,
    output logic [1:0] fsm_state
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SCW = $clog2(SKEW_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t         state;
    logic [1:0]     lane_ptr;
    logic [SCW-1:0] skew_cnt;

    logic [7:0]    mem  [4][DEPTH];
    logic [AW-1:0] wptr [4];
    logic [AW-1:0] rptr [4];
    logic [CW-1:0] cnt  [4];

    logic [3:0] vin;
    logic [7:0] din [4];
    logic [3:0] empty, full, push, pop, wr_en, ovf;
    logic       all_ne, any_ne, ovf_any;
    logic [7:0] head;

    assign vin       = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign fsm_state = state;

    always_comb begin
        din[0] = data_in0;
        din[1] = data_in1;
        din[2] = data_in2;
        din[3] = data_in3;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (cnt[i] == '0);
            full[i]  = (cnt[i] == CW'(DEPTH));
            pop[i]   = (state == RUN) && (lane_ptr == 2'(i)) && !empty[i];
            push[i]  = vin[i] && (state != ERROR);
            // A full FIFO may still accept a byte if its head leaves in the same cycle.
            wr_en[i] = push[i] && (!full[i] || pop[i]);
            ovf[i]   = push[i] && full[i] && !pop[i];
        end
        all_ne  = ~|empty;
        any_ne  = ~&empty;
        ovf_any = |ovf;
        head    = mem[lane_ptr][rptr[lane_ptr]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en[i]) mem[i][wptr[i]] <= din[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state == ERROR) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                    cnt[i]  <= '0;
                end else begin
                    if (wr_en[i]) wptr[i] <= wptr[i] + 1'b1;
                    if (pop[i])   rptr[i] <= rptr[i] + 1'b1;
                    if (wr_en[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
                    else if (!wr_en[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lane_ptr     <= 2'd0;
            skew_cnt     <= '0;
            data_out     <= 8'h00;
            valid_out    <= 1'b0;
            aligned      <= 1'b0;
            overflow_err <= 1'b0;
            skew_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    lane_ptr  <= 2'd0;
                    if (all_ne) begin
                        state   <= RUN;
                        aligned <= 1'b1;
                    end else if (any_ne) begin
                        state    <= ALIGN;
                        skew_cnt <= '0;
                    end
                end
                ALIGN: begin
                    valid_out <= 1'b0;
                    if (all_ne) begin
                        state    <= RUN;
                        aligned  <= 1'b1;
                        lane_ptr <= 2'd0;
                    end else begin
                        skew_cnt <= skew_cnt + 1'b1;
                        if (skew_cnt == SCW'(SKEW_MAX - 1)) begin
                            state    <= ERROR;
                            skew_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!empty[lane_ptr]) begin
                        data_out  <= head;
                        valid_out <= 1'b1;
                        lane_ptr  <= lane_ptr + 2'd1;
                    end else begin
                        valid_out <= 1'b0;
                        // Realign only on a word boundary so lane order is never broken.
                        if (lane_ptr == 2'd0 && !any_ne) begin
                            state   <= IDLE;
                            aligned <= 1'b0;
                        end
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                    aligned   <= 1'b0;
                end
            endcase
            if (ovf_any) begin
                state        <= ERROR;
                overflow_err <= 1'b1;
                valid_out    <= 1'b0;
                aligned      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_byte_unstriping_rx.sv
// Directed bench for byte_unstriping_rx: aligned word, skew, skew timeout, overflow,
// striper-style loopback and asynchronous reset in the middle of a word.
module tb_byte_unstriping_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic [7:0] data_out;
    logic       valid_out, aligned, overflow_err, skew_err;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    logic seen_valid;

    byte_unstriping_rx #(.DEPTH(4), .SKEW_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .valid_in0(valid_in0), .valid_in1(valid_in1),
        .valid_in2(valid_in2), .valid_in3(valid_in3),
        .data_in0(data_in0), .data_in1(data_in1),
        .data_in2(data_in2), .data_in3(data_in3),
        .data_out(data_out), .valid_out(valid_out), .aligned(aligned),
        .overflow_err(overflow_err), .skew_err(skew_err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out === 1'b1) begin
            seen_valid = 1'b1;
            got_q.push_back(data_out);
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
    endtask

    task automatic drive(input logic [3:0] mask, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        {valid_in3, valid_in2, valid_in1, valid_in0} = mask;
        data_in0 = b0;
        data_in1 = b1;
        data_in2 = b2;
        data_in3 = b3;
    endtask

    task automatic idle_in();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
        seen_valid = 1'b0;
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, " data_out"},     data_out,     8'h00);
        chk({tag, " valid_out"},    valid_out,    8'h00);
        chk({tag, " aligned"},      aligned,      8'h00);
        chk({tag, " overflow_err"}, overflow_err, 8'h00);
        chk({tag, " skew_err"},     skew_err,     8'h00);
        chk({tag, " state"},        fsm_state,    8'h00);
    endtask

    initial begin
        logic [7:0] w1[4];
        logic [7:0] w2[4];
        w1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        w2 = '{8'h55, 8'h66, 8'h77, 8'h88};
        seen_valid = 1'b0;
        idle_in();
        do_reset();
        chk_clear("reset");

        // 1: aligned word
        drive(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        tick();
        idle_in();
        tick();
        chk("t1 aligned@E1", aligned, 8'h01);
        chk("t1 valid@E1", valid_out, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t1 valid[%0d]", k), valid_out, 8'h01);
            chk($sformatf("t1 data[%0d]", k), data_out, w1[k]);
        end
        tick();
        chk("t1 valid after", valid_out, 8'h00);
        chk("t1 hold data", data_out, 8'h44);
        chk("t1 back idle", aligned, 8'h00);

        // 2: lane2 three cycles late
        drive(4'b1011, 8'h11, 8'h22, 8'h00, 8'h44);
        tick();
        idle_in();
        tick();
        chk("t2 state align", fsm_state, 8'h01);
        tick();
        drive(4'b0100, 8'h00, 8'h00, 8'h33, 8'h00);
        tick();
        idle_in();
        chk("t2 still align", fsm_state, 8'h01);
        chk("t2 no early out", valid_out, 8'h00);
        tick();
        chk("t2 aligned", aligned, 8'h01);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t2 valid[%0d]", k), valid_out, 8'h01);
            chk($sformatf("t2 data[%0d]", k), data_out, w1[k]);
        end
        chk("t2 skew_err", skew_err, 8'h00);
        tick();

        // 3: lane3 never arrives
        do_reset();
        drive(4'b0111, 8'h11, 8'h22, 8'h33, 8'h00);
        tick();
        idle_in();
        for (int k = 0; k < 8; k++) tick();
        chk("t3 skew_err before timeout", skew_err, 8'h00);
        tick();
        chk("t3 skew_err", skew_err, 8'h01);
        chk("t3 state error", fsm_state, 8'h03);
        drive(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        tick();
        idle_in();
        for (int k = 0; k < 6; k++) tick();
        chk("t3 no output", seen_valid, 8'h00);
        chk("t3 skew_err sticky", skew_err, 8'h01);
        chk("t3 aligned", aligned, 8'h00);

        // 4: DEPTH+1 writes to lane0
        do_reset();
        for (int w = 0; w < 5; w++) begin
            drive(4'b0001, 8'(w + 1), 8'h00, 8'h00, 8'h00);
            tick();
            if (w == 3) chk("t4 no overflow at 4th", overflow_err, 8'h00);
        end
        idle_in();
        chk("t4 overflow_err", overflow_err, 8'h01);
        chk("t4 state error", fsm_state, 8'h03);
        for (int k = 0; k < 4; k++) tick();
        chk("t4 no output", seen_valid, 8'h00);
        chk("t4 skew_err", skew_err, 8'h00);

        // 5: striper-style loopback, one word every four clocks
        do_reset();
        first_cyc = -1;
        last_cyc  = -1;
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3));
            tick();
            idle_in();
            tick();
            tick();
            tick();
        end
        for (int k = 0; k < 6; k++) tick();
        chk("t5 byte count", 8'(got_q.size()), 8'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < got_q.size()) chk($sformatf("t5 byte[%0d]", k), got_q[k], exp_q[k]);
        end
        chk("t5 one per clock", 8'(last_cyc - first_cyc), 8'd15);
        chk("t5 overflow_err", overflow_err, 8'h00);
        chk("t5 skew_err", skew_err, 8'h00);

        // 6: async reset after the second byte, then a clean word
        drive(4'b1111, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        tick();
        idle_in();
        tick();
        tick();
        chk("t6 first byte", data_out, 8'hAA);
        tick();
        chk("t6 second byte", data_out, 8'hBB);
        #3;
        reset = 1'b1;
        #1;
        chk_clear("t6 async reset");
        tick();
        reset = 1'b0;
        drive(4'b1111, 8'h55, 8'h66, 8'h77, 8'h88);
        tick();
        idle_in();
        tick();
        chk("t6 aligned", aligned, 8'h01);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6 valid[%0d]", k), valid_out, 8'h01);
            chk($sformatf("t6 data[%0d]", k), data_out, w2[k]);
        end
        chk("t6 overflow_err", overflow_err, 8'h00);
        chk("t6 skew_err", skew_err, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
